// File: rtl/cmu_2way.sv
// cmu_2way: 2-way set-associative, write-back, write-allocate data cache
// controller. It sits between the MEM stage and a word-wide memory bus that
// uses a cs/we/ack handshake. Tag and data arrays are internal, and each set
// has one LRU bit.
// Optional build macro: CMU_PERF_CNT_EN adds the perf_hit and perf_miss
// counters.
module cmu_2way #(
  parameter int SET_BITS         = 4,
  parameter int LINE_WORDS_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_rw,
  input  logic        en_r,
  input  logic        en_w,
  input  logic [31:0] data_w,
  output logic [31:0] data_r,
  output logic        stall,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
`ifdef CMU_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);

  localparam int TAG_BITS = 32 - SET_BITS - LINE_WORDS_WIDTH - 2;
  localparam int SETS     = 1 << SET_BITS;
  localparam int WORDS    = 1 << LINE_WORDS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_BACK, S_BACK_WAIT, S_FILL, S_FILL_WAIT
  } state_t;

  localparam logic [LINE_WORDS_WIDTH-1:0] WC_ZERO = '0;
  localparam logic [LINE_WORDS_WIDTH-1:0] WC_LAST = '1;

  state_t                      state;
  logic [LINE_WORDS_WIDTH-1:0] word_count;
  logic [LINE_WORDS_WIDTH-1:0] wc_next;
  logic                        victim_way;
  logic [31:0]                 data_r_q;

  logic [31:0]         data_arr  [2][SETS][WORDS];
  logic [TAG_BITS-1:0] tag_arr   [2][SETS];
  logic [SETS-1:0]     valid_arr [2];
  logic [SETS-1:0]     dirty_arr [2];
  logic [SETS-1:0]     lru;

  logic [TAG_BITS-1:0]         req_tag;
  logic [SET_BITS-1:0]         req_idx;
  logic [LINE_WORDS_WIDTH-1:0] req_word;
  logic                        unused_byte_bits;

  logic        req, hit0, hit1, hit_way, idle_hit, idle_miss, vict_sel;
  logic [31:0] hit_word;

  assign req_tag          = addr_rw[31:32-TAG_BITS];
  assign req_idx          = addr_rw[SET_BITS+LINE_WORDS_WIDTH+1:LINE_WORDS_WIDTH+2];
  assign req_word         = addr_rw[LINE_WORDS_WIDTH+1:2];
  assign unused_byte_bits = ^addr_rw[1:0];

  assign req       = en_r | en_w;
  assign hit0      = valid_arr[0][req_idx] && (tag_arr[0][req_idx] == req_tag);
  assign hit1      = valid_arr[1][req_idx] && (tag_arr[1][req_idx] == req_tag);
  // Way 0 takes priority if both ways ever match.
  assign hit_way   = hit0 ? 1'b0 : 1'b1;
  assign hit_word  = data_arr[hit_way][req_idx][req_word];
  assign idle_hit  = (state == S_IDLE) && req && (hit0 || hit1);
  assign idle_miss = (state == S_IDLE) && req && !(hit0 || hit1);
  assign wc_next   = word_count + 1'b1;

  assign stall  = (state != S_IDLE) || idle_miss;
  assign data_r = idle_hit ? hit_word : data_r_q;

  // Pick the victim: the first invalid way (way 0 first), otherwise the LRU way.
  always_comb begin
    vict_sel = lru[req_idx];
    if (!valid_arr[0][req_idx])      vict_sel = 1'b0;
    else if (!valid_arr[1][req_idx]) vict_sel = 1'b1;
  end

  // Controller FSM, line status bits and the registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      word_count   <= '0;
      victim_way   <= 1'b0;
      mem_cs_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      data_r_q     <= '0;
      valid_arr[0] <= '0;
      valid_arr[1] <= '0;
      dirty_arr[0] <= '0;
      dirty_arr[1] <= '0;
      lru          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_hit) begin
            data_r_q     <= hit_word;
            lru[req_idx] <= ~hit_way;
            if (en_w) dirty_arr[hit_way][req_idx] <= 1'b1;
          end else if (idle_miss) begin
            victim_way <= vict_sel;
            word_count <= '0;
            mem_cs_o   <= 1'b1;
            if (valid_arr[vict_sel][req_idx] && dirty_arr[vict_sel][req_idx]) begin
              state      <= S_BACK;
              mem_we_o   <= 1'b1;
              mem_addr_o <= {tag_arr[vict_sel][req_idx], req_idx, WC_ZERO, 2'b00};
              mem_data_o <= data_arr[vict_sel][req_idx][0];
            end else begin
              state      <= S_FILL;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {req_tag, req_idx, WC_ZERO, 2'b00};
              mem_data_o <= '0;
            end
          end
        end
        S_BACK: begin
          if (mem_ack_i) begin
            word_count <= wc_next;
            if (word_count == WC_LAST) begin
              state      <= S_BACK_WAIT;
              mem_cs_o   <= 1'b0;
              mem_we_o   <= 1'b0;
              mem_addr_o <= '0;
              mem_data_o <= '0;
            end else begin
              mem_addr_o <= {tag_arr[victim_way][req_idx], req_idx, wc_next, 2'b00};
              mem_data_o <= data_arr[victim_way][req_idx][wc_next];
            end
          end
        end
        S_BACK_WAIT: begin
          state      <= S_FILL;
          word_count <= '0;
          mem_cs_o   <= 1'b1;
          mem_we_o   <= 1'b0;
          mem_addr_o <= {req_tag, req_idx, WC_ZERO, 2'b00};
        end
        S_FILL: begin
          if (mem_ack_i) begin
            word_count <= wc_next;
            if (word_count == WC_LAST) begin
              state      <= S_FILL_WAIT;
              mem_cs_o   <= 1'b0;
              mem_addr_o <= '0;
            end else begin
              mem_addr_o <= {req_tag, req_idx, wc_next, 2'b00};
            end
          end
        end
        S_FILL_WAIT: begin
          state                           <= S_IDLE;
          word_count                      <= '0;
          valid_arr[victim_way][req_idx]  <= 1'b1;
          dirty_arr[victim_way][req_idx]  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data array writes: write hits, refill words, and the tag at fill end.
  always_ff @(posedge clk) begin
    if (idle_hit && en_w)
      data_arr[hit_way][req_idx][req_word] <= data_w;
    if (state == S_FILL && mem_ack_i)
      data_arr[victim_way][req_idx][word_count] <= mem_data_i;
    if (state == S_FILL_WAIT)
      tag_arr[victim_way][req_idx] <= req_tag;
  end

`ifdef CMU_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating counters for completed accesses and for miss starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (idle_hit)  perf_hit  <= sat_inc(perf_hit);
      if (idle_miss) perf_miss <= sat_inc(perf_miss);
    end
  end
`else
  // This build has no performance counters.
`endif

endmodule

// File: doc/cmu_2way.md
Name: cmu_2way

Overview:
- Parametrised successor to the single-line cache management unit.
- 2-way set-associative, write-back, write-allocate data cache controller with internal tag/data arrays and per-set LRU.
- Sits between the pipeline MEM stage (read/write + stall) and the word-wide memory bus (cs/we/ack handshake).

Parameters:
- SET_BITS, 4: log2 of set count; 16 sets.
- LINE_WORDS_WIDTH, 2: log2 of words per line; 4 words, 16 bytes.
- TAG_BITS, derived, not overridable: 32-SET_BITS-LINE_WORDS_WIDTH-2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- addr_rw  in  32  CPU byte address; bits [1:0] ignored.
- en_r  in  1  CPU read request.
- en_w  in  1  CPU write request; wins if en_r is also high.
- data_w  in  32  CPU write data.
- data_r  out  32  CPU read data.
- stall  out  1  hold the pipeline.
- mem_cs_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  32  memory word address, [1:0]=0.
- mem_data_o  out  32  memory write data.
- mem_data_i  in  32  memory read data.
- mem_ack_i  in  1  memory word accepted/returned.

Behaviour:
- Address split: tag=[31:32-TAG_BITS], index=[SET_BITS+LINE_WORDS_WIDTH+1:LINE_WORDS_WIDTH+2], word=[LINE_WORDS_WIDTH+1:2].
- Per way per set: valid, dirty, tag, 2^LINE_WORDS_WIDTH words. Per set: one LRU bit naming the least-recently-used way.
- Reset: all valid/dirty/LRU bits cleared in one cycle. State=S_IDLE, word_count=0. data_r=0, stall=0, mem_cs_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
- Reset mid-miss: abort immediately, all lines invalid, dirty data discarded, bus outputs 0 on the next cycle.
- Hit (S_IDLE, request, valid && tag match in either way):
  - stall=0 combinationally, data_r=hit word in the same cycle.
  - Write hit updates the word and sets dirty at the clock edge.
  - LRU points to the other way.
- Both ways matching cannot occur. If it does, way 0 wins.
- No request: stall=0, data_r holds its last value, no state change.
- Miss: stall=1 from the request cycle until the replayed hit cycle.
  - Victim = first invalid way (way 0 preferred), else the LRU way.
  - CPU must hold addr_rw/en/data_w stable while stall=1.
- FSM:
  - S_IDLE -> S_BACK if the victim is valid and dirty, else -> S_FILL. word_count=0.
  - S_BACK: mem_cs_o=1, mem_we_o=1, mem_addr_o={victim tag, index, word_count, 00}, mem_data_o=victim word. On ack, word_count++. Ack on the last word -> S_BACK_WAIT.
  - S_BACK_WAIT: 1 cycle, cs=0, word_count=0 -> S_FILL.
  - S_FILL: mem_cs_o=1, mem_we_o=0, mem_addr_o={addr tag, index, word_count, 00}. On ack, store mem_data_i into the victim word; word_count++. Ack on the last word -> S_FILL_WAIT.
  - S_FILL_WAIT: 1 cycle. Victim tag written, valid=1, dirty=0 -> S_IDLE. The request replays as a hit, which performs the write/read and the LRU update.
- Bus outputs are registered from the state/counter. Address/data stay stable until ack. No ack means wait indefinitely.
- word_count wraps at 2^LINE_WORDS_WIDTH; a wrap only occurs on the last ack.
- en_r and en_w deasserted during a miss: the line transfer completes anyway, then S_IDLE.
- Miss latency, no back-pressure, ack every cycle: clean = 2^LWW+2 cycles; dirty = 2*2^LWW+3 cycles.

Optional Feature:
- Macro CMU_PERF_CNT_EN.
- Defined: adds outputs perf_hit and perf_miss, each 32 bits.
  - perf_hit increments on each non-stalled completed access.
  - perf_miss increments on each S_IDLE->S_BACK/S_FILL transition.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then read 0x00000040 with mem returning 0x11,0x22,0x33,0x44 -> 4 fill reads to 0x40/44/48/4C, no writes; stall drops in cycle 7 with data_r=0x11.
- Write 0xDEADBEEF to 0x44 (hit), then read 0x44 -> stall=0 both cycles; data_r=0xDEADBEEF.
- Read 0x140 (same set, other way), touch 0x40, then read 0x240 -> victim is the 0x140 line (LRU), which is clean, so no write-back; the 0x40 line is retained (reread hits).
- Dirty 0x40, fill 0x140, touch 0x140, read 0x240 -> write-back to 0x40..0x4C with 0x44 = 0xDEADBEEF, one idle cycle, then fill 0x240.
- Delayed ack (3 idle cycles per word) -> mem_addr_o/mem_data_o stable until each ack; word_count advances only on ack.
- Assert rst during S_BACK word 2 -> bus idle next cycle; a subsequent read of 0x44 misses and refills.
